// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - requester, fill-command and RAM port A signal bundle for fb_write_arbiter
interface fb_write_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_grant;
    logic                  b_req;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_grant;
    logic                  fill_start;
    logic [DATA_WIDTH-1:0] fill_value;
    logic                  fill_busy;
    logic                  fill_done;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic                  ram_write_enable;
    logic                  ram_clk_enable;

    modport slave (
        input  a_req, a_addr, a_data, b_req, b_addr, b_data, fill_start, fill_value,
        output a_grant, b_grant, fill_busy, fill_done,
        output ram_address, ram_data_out, ram_write_enable, ram_clk_enable
    );

    modport master (
        output a_req, a_addr, a_data, b_req, b_addr, b_data, fill_start, fill_value,
        input  a_grant, b_grant, fill_busy, fill_done,
        input  ram_address, ram_data_out, ram_write_enable, ram_clk_enable
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - framebuffer port A write arbiter (round-robin A/B plus fill engine under FB_ARB_FILL_EN)
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int FILL_WORDS = 4096
) (
    input  logic              clk_in,
    input  logic              reset,
    fb_write_arbiter_if.slave bus
);
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_we_q, ram_we_d;
    logic                  a_grant_q, a_grant_d;
    logic                  b_grant_q, b_grant_d;
    logic                  last_a_q, last_a_d;
    logic                  a_elig, b_elig, win_a, win_b, arb_en;

    // A requester that is seeing its grant this cycle has not yet moved on to its next word.
    assign a_elig = bus.a_req & ~a_grant_q;
    assign b_elig = bus.b_req & ~b_grant_q;

    always_comb begin
        win_a = a_elig;
        win_b = b_elig;
        if (a_elig && b_elig) begin
            win_a = ~last_a_q;
            win_b = last_a_q;
        end
    end

`ifdef FB_ARB_FILL_EN
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(FILL_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    assign arb_en = (state_q == S_IDLE) && !bus.fill_start;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.fill_start) state_d = (LAST_ADDR == '0) ? S_DONE : S_FILL;
            S_FILL: if (cnt_q == LAST_ADDR) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
`else
    logic unused_fill;
    assign unused_fill = ^{bus.fill_start, bus.fill_value, (FILL_WORDS > 0)};
    assign arb_en      = 1'b1;
`endif

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        a_grant_d  = 1'b0;
        b_grant_d  = 1'b0;
        last_a_d   = last_a_q;
        if (arb_en && win_a) begin
            ram_addr_d = bus.a_addr;
            ram_data_d = bus.a_data;
            ram_we_d   = 1'b1;
            a_grant_d  = 1'b1;
            last_a_d   = 1'b1;
        end else if (arb_en && win_b) begin
            ram_addr_d = bus.b_addr;
            ram_data_d = bus.b_data;
            ram_we_d   = 1'b1;
            b_grant_d  = 1'b1;
            last_a_d   = 1'b0;
        end
`ifdef FB_ARB_FILL_EN
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        // Address 0 goes out on the start edge itself, so the counter then holds the next address.
        case (state_q)
            S_IDLE: begin
                if (bus.fill_start) begin
                    ram_addr_d = '0;
                    ram_data_d = bus.fill_value;
                    ram_we_d   = 1'b1;
                    busy_d     = 1'b1;
                    fill_val_d = bus.fill_value;
                    cnt_d      = CW'(1);
                end
            end
            S_FILL: begin
                ram_addr_d = cnt_q[ADDR_WIDTH-1:0];
                ram_data_d = fill_val_q;
                ram_we_d   = 1'b1;
                busy_d     = 1'b1;
                cnt_d      = cnt_q + CW'(1);
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            a_grant_q  <= 1'b0;
            b_grant_q  <= 1'b0;
            last_a_q   <= 1'b0;
`ifdef FB_ARB_FILL_EN
            cnt_q      <= '0;
            fill_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`endif
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            a_grant_q  <= a_grant_d;
            b_grant_q  <= b_grant_d;
            last_a_q   <= last_a_d;
`ifdef FB_ARB_FILL_EN
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`endif
        end
    end

    assign bus.ram_address      = ram_addr_q;
    assign bus.ram_data_out     = ram_data_q;
    assign bus.ram_write_enable = ram_we_q;
    assign bus.ram_clk_enable   = ram_we_q;
    assign bus.a_grant          = a_grant_q;
    assign bus.b_grant          = b_grant_q;
`ifdef FB_ARB_FILL_EN
    assign bus.fill_busy        = busy_q;
    assign bus.fill_done        = done_q;
`else
    assign bus.fill_busy        = 1'b0;
    assign bus.fill_done        = 1'b0;
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NW = 4096;

    logic clk_in = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   errs;

    fb_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_write_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FILL_WORDS(NW)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int we, input int addr, input int data,
                           input int ag, input int bg, input int busy, input int done);
        chk({tag, ".we"},    32'(bus.ram_write_enable), we);
        chk({tag, ".ce"},    32'(bus.ram_clk_enable),   we);
        chk({tag, ".addr"},  32'(bus.ram_address),      addr);
        chk({tag, ".data"},  32'(bus.ram_data_out),     data);
        chk({tag, ".agnt"},  32'(bus.a_grant),          ag);
        chk({tag, ".bgnt"},  32'(bus.b_grant),          bg);
        chk({tag, ".busy"},  32'(bus.fill_busy),        busy);
        chk({tag, ".done"},  32'(bus.fill_done),        done);
    endtask

    initial begin
        reset          = 1'b1;
        bus.a_req      = 1'b1;
        bus.a_addr     = 12'h7FF;
        bus.a_data     = 8'hEE;
        bus.b_req      = 1'b1;
        bus.b_addr     = 12'h6AA;
        bus.b_data     = 8'hDD;
        bus.fill_start = 1'b1;
        bus.fill_value = 8'h99;
        step();
        chk_out("rst0", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_out("rst1", 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        bus.fill_start = 1'b0;
        step();
        chk_out("idle", 0, 0, 0, 0, 0, 0, 0);

        // single A write, one-cycle latency, one-cycle grant
        bus.a_req  = 1'b1;
        bus.a_addr = 12'h010;
        bus.a_data = 8'h5A;
        step();
        chk_out("a_wr", 1, 'h010, 'h5A, 1, 0, 0, 0);
        bus.a_req = 1'b0;
        step();
        chk_out("a_hold", 0, 'h010, 'h5A, 0, 0, 0, 0);

        // pointer back to A-preferred after reset; continuous A and B alternate
        reset = 1'b1;
        step();
        chk_out("rst2", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        bus.a_req  = 1'b1;
        bus.a_addr = 12'h100;
        bus.a_data = 8'h11;
        bus.b_req  = 1'b1;
        bus.b_addr = 12'h200;
        bus.b_data = 8'h22;
        step();
        chk_out("alt0", 1, 'h100, 'h11, 1, 0, 0, 0);
        step();
        chk_out("alt1", 1, 'h200, 'h22, 0, 1, 0, 0);
        step();
        chk_out("alt2", 1, 'h100, 'h11, 1, 0, 0, 0);
        step();
        chk_out("alt3", 1, 'h200, 'h22, 0, 1, 0, 0);

        // single requester holding req: one write per two cycles, no duplicate
        bus.b_req  = 1'b0;
        bus.a_addr = 12'h033;
        bus.a_data = 8'h44;
        step();
        chk_out("solo0", 1, 'h033, 'h44, 1, 0, 0, 0);
        bus.a_addr = 12'h034;
        bus.a_data = 8'h45;
        step();
        chk_out("solo_gap", 0, 'h033, 'h44, 0, 0, 0, 0);
        step();
        chk_out("solo1", 1, 'h034, 'h45, 1, 0, 0, 0);
        bus.a_req = 1'b0;
        step();
        chk_out("solo_end", 0, 'h034, 'h45, 0, 0, 0, 0);

        // A granted last, both now request: B wins
        bus.a_req  = 1'b1;
        bus.a_addr = 12'h0AA;
        bus.a_data = 8'h01;
        bus.b_req  = 1'b1;
        bus.b_addr = 12'h0BB;
        bus.b_data = 8'h02;
        step();
        chk_out("rr_b", 1, 'h0BB, 'h02, 0, 1, 0, 0);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        step();
        chk_out("rr_idle", 0, 'h0BB, 'h02, 0, 0, 0, 0);

`ifdef FB_ARB_FILL_EN
        // fill beats a simultaneous A request; A waits until after fill_done
        bus.fill_start = 1'b1;
        bus.fill_value = 8'h00;
        bus.a_req      = 1'b1;
        bus.a_addr     = 12'h055;
        bus.a_data     = 8'h66;
        step();
        chk_out("fill0", 1, 0, 0, 0, 0, 1, 0);
        bus.fill_start = 1'b0;
        errs = 0;
        for (int i = 1; i < NW; i++) begin
            bus.fill_start = (i == 5);
            bus.fill_value = 8'h77;
            step();
            if (bus.ram_address !== i[AW-1:0] || bus.ram_data_out !== 8'h00 ||
                bus.ram_write_enable !== 1'b1 || bus.a_grant !== 1'b0 ||
                bus.fill_busy !== 1'b1 || bus.fill_done !== 1'b0)
                errs++;
        end
        bus.fill_start = 1'b0;
        chk("fill_seq", errs, 0);
        step();
        chk_out("fill_done", 0, 'hFFF, 'h00, 0, 0, 0, 1);
        step();
        chk_out("fill_after", 1, 'h055, 'h66, 1, 0, 0, 0);
        bus.a_req = 1'b0;
        step();
        chk_out("fill_post", 0, 'h055, 'h66, 0, 0, 0, 0);

        // reset at address 0x100 aborts; restart begins at 0
        bus.fill_start = 1'b1;
        bus.fill_value = 8'hA5;
        step();
        bus.fill_start = 1'b0;
        repeat (256) step();
        chk("abort_at", 32'(bus.ram_address), 'h100);
        reset = 1'b1;
        step();
        chk_out("abort_rst", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        errs = 0;
        repeat (6) begin
            step();
            if (bus.ram_write_enable !== 1'b0 || bus.fill_done !== 1'b0 || bus.fill_busy !== 1'b0)
                errs++;
        end
        chk("abort_quiet", errs, 0);
        bus.fill_start = 1'b1;
        bus.fill_value = 8'h3C;
        step();
        chk_out("restart0", 1, 0, 'h3C, 0, 0, 1, 0);
        bus.fill_start = 1'b0;
        step();
        chk_out("restart1", 1, 1, 'h3C, 0, 0, 1, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
`else
        // fill logic compiled out: fill_start has no effect on RAM or arbitration
        bus.fill_start = 1'b1;
        bus.fill_value = 8'hFF;
        step();
        chk_out("nofill0", 0, 'h0BB, 'h02, 0, 0, 0, 0);
        bus.a_req  = 1'b1;
        bus.a_addr = 12'h321;
        bus.a_data = 8'h9C;
        step();
        chk_out("nofill_arb", 1, 'h321, 'h9C, 1, 0, 0, 0);
        bus.fill_start = 1'b0;
        bus.a_req = 1'b0;
        step();
        chk_out("nofill_end", 0, 'h321, 'h9C, 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
